rr_mux_arbiter: RTL
===================

Name: rr_mux_arbiter

Overview:
- Round-robin arbiter/scheduler that shares one 16:1 single-bit selection path among 16 requesters.
- Grants one requester at a time, drives the 4-bit select, and registers the selected data bit with a valid flag.
- Sits in front of the mux16to1 datapath; sel drives the mux select input.
- Bounded hold time gives fairness under contention.

Parameters:
- MAX_HOLD, 4: max consecutive cycles a grant is held while another requester is waiting; legal range 1..15.

Ports:
- clk, input, 1: rising-edge clock.
- rst, input, 1: asynchronous active-high reset.
- req, input, 16: request lines. req[i] is held high while requester i wants the path.
- in, input, 16: data bits; bit i belongs to requester i.
- sel, output, 4: index of the current or last grantee; drives the mux select.
- grant, output, 16: one-hot grant, all zero when idle.
- grant_valid, output, 1: high while a grant is active (equals |grant).
- out, output, 1: registered data bit in[sel].
- out_valid, output, 1: high when out carries a granted sample.

Behaviour:
- Clocking and reset (decided): one clock, clk. Reset rst is asynchronous and active-high.
- Reset values: sel=0, grant=0, grant_valid=0, out=0, out_valid=0; internal ptr=0, hold_cnt=0, state=IDLE.
- Reset asserted mid-grant clears all of the above immediately, without waiting for a clock edge.
- Internal state:
  - ptr (4 bits): highest-priority index.
  - hold_cnt (4 bits).
  - FSM states: IDLE, GRANT.
- Arbitration function: search req starting at ptr, upward, wrapping 15->0. Pick the first set bit, i.
- IDLE state:
  - If req != 0 at an edge: go to GRANT at that edge with grant=onehot(i), sel=i, grant_valid=1, hold_cnt=1.
  - Grant latency: one cycle from req sampled high to grant visible.
  - If req == 0: stay in IDLE with grant=0. sel keeps its last value.
- GRANT state, evaluated each edge with g = sel:
  - Release condition: req[g]==0, OR (hold_cnt==MAX_HOLD AND (req & ~onehot(g)) != 0).
  - No release: keep grant; hold_cnt <= min(hold_cnt+1, MAX_HOLD). The counter saturates, so an uncontended grant is held indefinitely.
  - On release: ptr <= g+1 mod 16 (15 wraps to 0).
  - Release with another request pending: arbitrate in the same edge using the new ptr (g is searched last). Load the new grant with hold_cnt=1. There is no idle cycle between grants.
  - Release with no other request pending: go to IDLE, grant=0, grant_valid=0.
  - If req[g] drops in the same cycle that hold expires, this is a single release; the rules above apply.
  - MAX_HOLD=1 means re-arbitration on every cycle whenever there is contention.
- Data path, every edge:
  - out <= in[sel], but only when grant_valid==1; otherwise out holds its value.
  - out_valid <= grant_valid.
  - out and out_valid therefore lag the grant by exactly one cycle. A sample belongs to the grantee of the previous cycle.
- Invariants:
  - grant is always zero or one-hot.
  - When grant_valid==1, grant[sel]==1.
  - A requester is never granted while its req is low at the arbitration edge.

Test Plan:
1. Reset: drive rst high mid-simulation with req=16'hFFFF. Required: sel=0, grant=0, grant_valid=0, out=0, out_valid=0 immediately, before any clock edge. After release, the first grant goes to index 0.
2. Single requester: req=16'h0020 for 10 cycles, then 0. Required:
   - grant=16'h0020 and sel=5 one cycle after req rises, held all 10 cycles with no expiry.
   - Goes IDLE one cycle after req drops.
   - The next lone req=16'hFFFF is granted to index 6.
3. Contention with MAX_HOLD=4: req=16'h8001 held constant. Required: grant sequence 0,0,0,0,15,15,15,15,0,... with grant_valid continuously 1 and no gap cycles.
4. Wrap-around: after a grant to 14 is released, req=16'h4001. Required: next grant is 0 (ptr=15 wraps), not 14. Then a grant to 15 releases to ptr=0.
5. Data path: in=16'h0F0F, req[3] for 2 cycles then req[4] for 2 cycles. Required: out=1,1 then 0,0, each out_valid=1 and one cycle behind the matching grant.
6. Early drop: grantee drops req after 2 cycles while others are pending. Required: immediate back-to-back grant to the next index above the grantee; hold_cnt restarts at 1.

Source files
------------

// File: rtl/rr_mux_arbiter_if.sv
// rr_mux_arbiter_if: request/data/grant bundle between requesters and the
// round-robin arbiter sitting in front of a 16:1 single-bit mux.
//   req         : per-requester request lines (held while the path is wanted)
//   in          : per-requester data bits, bit i belongs to requester i
//   sel         : index of the current or last grantee (mux select)
//   grant       : one-hot grant, all zero when idle
//   grant_valid : high while a grant is active
//   out         : registered data bit of the previous cycle's grantee
//   out_valid   : high when out carries a granted sample
// Modports: master = requester side, slave = arbiter side.
interface rr_mux_arbiter_if;
  logic [15:0] req;
  logic [15:0] in;
  logic [3:0]  sel;
  logic [15:0] grant;
  logic        grant_valid;
  logic        out;
  logic        out_valid;

  modport master (
    output req, in,
    input  sel, grant, grant_valid, out, out_valid
  );

  modport slave (
    input  req, in,
    output sel, grant, grant_valid, out, out_valid
  );
endinterface

// File: rtl/rr_mux_arbiter.sv
// rr_mux_arbiter: round-robin arbiter sharing one 16:1 single-bit selection
// path among 16 requesters. A grant is held while its requester keeps req
// high, but for at most MAX_HOLD consecutive cycles once someone else waits.
// The selected data bit is registered one cycle behind the grant.
// Ports:
//   clk : rising-edge clock
//   rst : asynchronous active-high reset
//   bus : rr_mux_arbiter_if.slave (req, in -> sel, grant, grant_valid,
//         out, out_valid)
// Parameter:
//   MAX_HOLD : contended hold limit in cycles, legal range 1..15
module rr_mux_arbiter #(
  parameter int MAX_HOLD = 4
) (
  input  logic           clk,
  input  logic           rst,
  rr_mux_arbiter_if.slave bus
);

  localparam logic [3:0] HOLD_LIMIT = 4'(MAX_HOLD);

  typedef enum logic {IDLE, GRANT} state_t;

  state_t     state, state_nxt;
  logic [3:0] ptr, ptr_nxt;
  logic [3:0] hold_cnt, hold_nxt;
  logic [3:0] sel_p0, sel_nxt;
  logic       out_p1, vld_p1;
  logic       grant_valid_c;
  logic [15:0] grant_c;

  // First set bit of r at or above base, wrapping 15 -> 0. Callers only use
  // the result when r is non-zero.
  function automatic logic [3:0] rr_pick(input logic [15:0] r, input logic [3:0] base);
    logic [3:0] idx;
    logic [3:0] j;
    logic       found;
    idx   = base;
    found = 1'b0;
    for (int k = 0; k < 16; k++) begin
      j = base + 4'(k);
      if (!found && r[j]) begin
        idx   = j;
        found = 1'b1;
      end
    end
    return idx;
  endfunction

  // State register: control state, selection index and datapath register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state    <= IDLE;
      ptr      <= 4'd0;
      hold_cnt <= 4'd0;
      sel_p0   <= 4'd0;
      out_p1   <= 1'b0;
      vld_p1   <= 1'b0;
    end else begin
      state    <= state_nxt;
      ptr      <= ptr_nxt;
      hold_cnt <= hold_nxt;
      sel_p0   <= sel_nxt;
      // out stage: sample the current grantee's bit, hold when idle
      if (grant_valid_c) begin
        out_p1 <= bus.in[sel_p0];
      end
      vld_p1 <= grant_valid_c;
    end
  end

  // Next-state logic: arbitration, hold counting and release.
  always_comb begin
    logic [15:0] others;
    logic        release_g;
    logic [3:0]  ptr_rel;

    state_nxt = state;
    ptr_nxt   = ptr;
    hold_nxt  = hold_cnt;
    sel_nxt   = sel_p0;
    others    = bus.req & ~(16'h0001 << sel_p0);
    release_g = 1'b0;
    ptr_rel   = sel_p0 + 4'd1;

    unique case (state)
      IDLE: begin
        if (bus.req != 16'h0000) begin
          state_nxt = GRANT;
          sel_nxt   = rr_pick(bus.req, ptr);
          hold_nxt  = 4'd1;
        end
      end
      GRANT: begin
        release_g = !bus.req[sel_p0] ||
                    ((hold_cnt == HOLD_LIMIT) && (others != 16'h0000));
        if (release_g) begin
          ptr_nxt = ptr_rel;
          if (others != 16'h0000) begin
            // Back-to-back handover; the old grantee is searched last.
            sel_nxt  = rr_pick(others, ptr_rel);
            hold_nxt = 4'd1;
          end else begin
            state_nxt = IDLE;
          end
        end else if (hold_cnt < HOLD_LIMIT) begin
          // Saturating, so an uncontended grant is held indefinitely.
          hold_nxt = hold_cnt + 4'd1;
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  // Output logic: grant decoded from state so reset clears it at once.
  always_comb begin
    grant_valid_c = (state == GRANT);
    grant_c       = 16'h0000;
    if (grant_valid_c) begin
      grant_c = 16'h0001 << sel_p0;
    end
  end

  assign bus.sel         = sel_p0;
  assign bus.grant       = grant_c;
  assign bus.grant_valid = grant_valid_c;
  assign bus.out         = out_p1;
  assign bus.out_valid   = vld_p1;

endmodule
